load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Memory-access stage between the pipeline's execute/mem control and data_memory.
- Accepts one load or store per request over a valid/ready handshake.
- Checks alignment, drives data_memory's word-wide read/write port, and performs read-modify-write for byte/half stores, because data_memory has no byte enables.
- Returns sign/zero-extended load data with a one-cycle response pulse.

Parameters:
- ADDR_W, 32, byte address width on request and memory ports.
- DATA_W, 32, data width; fixed at 32 for RV32; other values unsupported.
- TAG_W, 5, destination-register tag carried request->response.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_is_store  in  1  1=store, 0=load.
- req_size  in  2  00=byte, 01=half, 10=word, 11=illegal.
- req_unsigned  in  1  loads: 1=zero-extend (LBU/LHU).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-justified.
- req_tag  in  TAG_W  returned on resp_tag.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_W  extended load data; 0 for stores/faults.
- resp_tag  out  TAG_W  captured req_tag.
- resp_misaligned  out  1  alignment/illegal-size fault, valid with resp_valid.
- mem_addr  out  ADDR_W  word-aligned address to data_memory.
- mem_write_data  out  DATA_W  full word to write.
- mem_write_en  out  1  data_memory write strobe.
- mem_read_en  out  1  data_memory read strobe.
- mem_read_data  in  DATA_W  data_memory read data; valid combinationally in the same cycle mem_read_en and mem_addr are driven.

Behaviour:
- Reset (async assert): state=IDLE; all captured registers 0. Outputs: req_ready=1, resp_valid=0, resp_rdata=0, resp_tag=0, resp_misaligned=0, mem_addr=0, mem_write_data=0, mem_write_en=0, mem_read_en=0.
- Reset mid-operation: in-flight request dropped with no response. No memory strobe is asserted after the reset edge.
- Acceptance: a request is accepted on a rising edge where req_valid && req_ready. All req_* fields are registered then; they are don't-care afterwards.
- Fault condition: size 11; half with addr[0]=1; word with addr[1:0]!=0.
- States:
  - IDLE: on accept, go to RESP if fault; LOAD_RD if load; STORE_WR if word store; STORE_RD if byte/half store.
  - LOAD_RD: mem_read_en=1. Capture the extracted/extended lane from mem_read_data. -> RESP.
  - STORE_RD: mem_read_en=1. Capture mem_read_data merged with store data at the addressed lane. -> STORE_WR.
  - STORE_WR: mem_write_en=1; mem_write_data = merged word, or req_wdata for word stores. -> RESP.
  - RESP: resp_valid=1 with resp_rdata/resp_tag/resp_misaligned. -> IDLE. No response backpressure.
- Memory port rules:
  - mem_addr = {addr[ADDR_W-1:2],2'b00} whenever not IDLE; holds its last value in IDLE.
  - mem_read_en and mem_write_en are never both 1.
  - A faulting request causes no memory strobe.
- Lane rules, little-endian:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - Signed loads replicate the lane MSB into the upper bits; unsigned loads zero-fill.
  - Stores use only req_wdata[7:0] (byte) or [15:0] (half).
- Latency, counted from the accept edge to the edge ending resp_valid:
  - Fault: 1 cycle.
  - Load: 2 cycles.
  - Word store: 2 cycles.
  - Byte/half store: 3 cycles.
- Throughput: next accept no earlier than the edge after the RESP cycle; req_ready is 0 in all non-IDLE states.

Decomposition:
- Shared package lsu_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - state enum IDLE/LOAD_RD/STORE_RD/STORE_WR/RESP.
  - misalignment-check function.
- Sub-module lsu_align, combinational: load extract+extend (word, addr[1:0], size, unsigned) and store merge (old word, wdata, addr[1:0], size). Shared by LOAD_RD and STORE_RD paths.

Test Plan:
- Word store 0xAABBCCDD @0x4, then word load @0x4 -> memory word 1 = 0xAABBCCDD; resp_rdata=0xAABBCCDD, resp_misaligned=0; resp_valid exactly 2 cycles after each accept.
- Byte store 0x55 @0x5 over 0xAABBCCDD -> one mem_read_en cycle at 0x4, then mem_write_en with 0xAABB55DD; resp_valid 3 cycles after accept.
- Loads over 0xAABB55DD:
  - LB @0x7 -> 0xFFFFFFAA.
  - LBU @0x7 -> 0x000000AA.
  - LH @0x6 -> 0xFFFFAABB.
  - LHU @0x4 -> 0x000055DD.
- Word load @0x6 -> resp_misaligned=1, resp_rdata=0, 1-cycle latency, no mem strobes. Half store 0xBEEF @0x9 with 0x11223344 at 0x8 -> misaligned, word unchanged. Size 11 @0x0 -> misaligned.
- req_valid held high with two queued requests (tags 3, 7) -> req_ready=0 while busy; second accepted on the edge after RESP; resp_tag 3 then 7.
- rst_n asserted during STORE_RD of byte store 0xEE @0x8 -> no mem_write_en ever; outputs at reset values; word @0x8 still 0x11223344; req_ready=1 after release.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared encodings and helpers for the load/store unit: access sizes, FSM states
// and the alignment check used at request acceptance.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_RD,
    STORE_RD,
    STORE_WR,
    RESP
  } state_e;

  // Illegal size counts as a fault alongside true misalignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] byte_off);
    logic fault;
    case (size)
      SZ_BYTE: fault = 1'b0;
      SZ_HALF: fault = byte_off[0];
      SZ_WORD: fault = (byte_off != 2'b00);
      default: fault = 1'b1;
    endcase
    return fault;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Bundles for the load/store unit: pipeline request/response side and the
// word-wide data_memory port.
interface lsu_req_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
);
  logic              req_valid;
  logic              req_ready;
  logic              req_is_store;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [TAG_W-1:0]  req_tag;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic [TAG_W-1:0]  resp_tag;
  logic              resp_misaligned;

  modport master (
    output req_valid, req_is_store, req_size, req_unsigned, req_addr, req_wdata, req_tag,
    input  req_ready, resp_valid, resp_rdata, resp_tag, resp_misaligned
  );
  modport slave (
    input  req_valid, req_is_store, req_size, req_unsigned, req_addr, req_wdata, req_tag,
    output req_ready, resp_valid, resp_rdata, resp_tag, resp_misaligned
  );
endinterface

interface lsu_mem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_write_en;
  logic              mem_read_en;
  logic [DATA_W-1:0] mem_read_data;

  modport master (
    output mem_addr, mem_write_data, mem_write_en, mem_read_en,
    input  mem_read_data
  );
  modport slave (
    input  mem_addr, mem_write_data, mem_write_en, mem_read_en,
    output mem_read_data
  );
endinterface

// File: rtl/load_store_unit_align.sv
// Little-endian lane logic: load extract/extend and store merge for byte/half
// accesses within a 32-bit memory word.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] word,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        byte_off,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] merged
);

  logic [4:0]        sh;
  logic [DATA_W-1:0] lane;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] ins;

  always_comb begin
    sh        = {byte_off, 3'b000};
    lane      = word >> sh;
    load_data = lane;
    mask      = '1;
    ins       = wdata;
    case (size)
      SZ_BYTE: begin
        load_data = {{(DATA_W-8){lane[7] & ~is_unsigned}}, lane[7:0]};
        mask      = DATA_W'(8'hFF) << sh;
        ins       = DATA_W'(wdata[7:0]) << sh;
      end
      SZ_HALF: begin
        load_data = {{(DATA_W-16){lane[15] & ~is_unsigned}}, lane[15:0]};
        mask      = DATA_W'(16'hFFFF) << sh;
        ins       = DATA_W'(wdata[15:0]) << sh;
      end
      default: ;
    endcase
    merged = (word & ~mask) | (ins & mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: aligns loads/stores onto a word-only data_memory port,
// doing read-modify-write for sub-word stores, with a one-cycle response pulse.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  lsu_req_if.slave   req,
  lsu_mem_if.master  mem
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic              store_q;
  logic              mis_q;
  logic [TAG_W-1:0]  tag_q;
  logic [DATA_W-1:0] data_q;

  logic              accept;
  logic              req_fault;
  logic              ready_c, rd_en_c, wr_en_c, resp_c;
  logic [DATA_W-1:0] load_data, merged;

  assign req_fault = is_misaligned(req.req_size, req.req_addr[1:0]);
  assign accept    = req.req_valid && ready_c;

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .word        (mem.mem_read_data),
    .wdata       (data_q),
    .byte_off    (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .load_data   (load_data),
    .merged      (merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready_c = 1'b0;
    rd_en_c = 1'b0;
    wr_en_c = 1'b0;
    resp_c  = 1'b0;
    case (state_q)
      IDLE: begin
        ready_c = 1'b1;
        if (req.req_valid) begin
          if (req_fault)                  state_d = RESP;
          else if (!req.req_is_store)     state_d = LOAD_RD;
          else if (req.req_size == SZ_WORD) state_d = STORE_WR;
          else                            state_d = STORE_RD;
        end
      end
      LOAD_RD:  begin rd_en_c = 1'b1; state_d = RESP;     end
      STORE_RD: begin rd_en_c = 1'b1; state_d = STORE_WR; end
      STORE_WR: begin wr_en_c = 1'b1; state_d = RESP;     end
      RESP:     begin resp_c  = 1'b1; state_d = IDLE;     end
      default:  state_d = IDLE;
    endcase
  end

  // data_q holds store data from accept, then the loaded lane or the merged word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      store_q <= 1'b0;
      mis_q   <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (accept) begin
      addr_q  <= req.req_addr;
      size_q  <= req.req_size;
      uns_q   <= req.req_unsigned;
      store_q <= req.req_is_store;
      mis_q   <= req_fault;
      tag_q   <= req.req_tag;
      data_q  <= req.req_wdata;
    end else if (state_q == LOAD_RD) begin
      data_q  <= load_data;
    end else if (state_q == STORE_RD) begin
      data_q  <= merged;
    end
  end

  assign req.req_ready       = ready_c;
  assign req.resp_valid      = resp_c;
  assign req.resp_tag        = tag_q;
  assign req.resp_misaligned = resp_c & mis_q;
  assign req.resp_rdata      = (resp_c && !store_q && !mis_q) ? data_q : '0;

  assign mem.mem_addr        = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem.mem_read_en     = rd_en_c;
  assign mem.mem_write_en    = wr_en_c;
  assign mem.mem_write_data  = wr_en_c ? data_q : '0;

endmodule
